// File: rtl/colordetect_cfg_arbiter_if.sv
// AXI4-Lite bus between the configuration arbiter and the ColorDetect2
// register bank. The master modport is the arbiter's view of the bus.
interface colordetect_cfg_arbiter_if;
  logic [31:0] m_axi_awaddr;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wvalid;
  logic        m_axi_wready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid;
  logic        m_axi_bready;
  logic [31:0] m_axi_araddr;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rvalid;
  logic        m_axi_rready;

  modport master (
    output m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
           m_axi_bready, m_axi_araddr, m_axi_arvalid, m_axi_rready,
    input  m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
           m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid
  );

  modport slave (
    input  m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
           m_axi_bready, m_axi_araddr, m_axi_arvalid, m_axi_rready,
    output m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
           m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid
  );
endinterface

// File: rtl/colordetect_cfg_arbiter.sv
// Two-requester round-robin arbiter that turns register commands into
// single AXI4-Lite read or write transactions, one in flight at a time.
module colordetect_cfg_arbiter #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                             ACLK,
  input  logic                             ARESET,
  input  logic [1:0]                       req_valid,
  input  logic [1:0]                       req_write,
  input  logic [3:0]                       req_idx,
  input  logic [63:0]                      req_wdata,
  output logic [1:0]                       req_ack,
  output logic [1:0]                       done,
  output logic [31:0]                      rdata,
  output logic [1:0]                       resp,
  colordetect_cfg_arbiter_if.master        m_axi
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    WR_B = 3'd2,
    RD_A = 3'd3,
    RD_R = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_last;      // requester granted most recently
  logic        r_id;        // requester owning the command in flight
  logic        r_awvalid;
  logic        r_wvalid;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [1:0]  r_resp;

  logic        w_any;
  logic        w_gid;
  logic        w_sel_write;
  logic [1:0]  w_sel_idx;
  logic [31:0] w_sel_wdata;
  logic        w_aw_hs;
  logic        w_w_hs;
  logic [1:0]  w_ack;
  logic [1:0]  w_done;
  logic        w_bready;
  logic        w_arvalid;
  logic        w_rready;

  // On a tie the requester that did not win last time gets the grant.
  assign w_any       = |req_valid;
  assign w_gid       = (req_valid == 2'b11) ? ~r_last : req_valid[1];
  assign w_sel_write = w_gid ? req_write[1]      : req_write[0];
  assign w_sel_idx   = w_gid ? req_idx[3:2]      : req_idx[1:0];
  assign w_sel_wdata = w_gid ? req_wdata[63:32]  : req_wdata[31:0];

  assign w_aw_hs = r_awvalid & m_axi.m_axi_awready;
  assign w_w_hs  = r_wvalid  & m_axi.m_axi_wready;

  // State register.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples pre-edge values regardless of statement order.
      r_state <= w_next;
    end
  end

  // Next-state decode and the state-decoded handshake outputs.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case can leave it holding a value (no latch).
    w_next    = r_state;
    w_ack     = 2'b00;
    w_done    = 2'b00;
    w_bready  = 1'b0;
    w_arvalid = 1'b0;
    w_rready  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_ack[w_gid] = ~ARESET;
          w_next       = w_sel_write ? WR : RD_A;
        end
      end
      WR: begin
        if ((!r_awvalid || m_axi.m_axi_awready) &&
            (!r_wvalid  || m_axi.m_axi_wready))
          w_next = WR_B;
      end
      WR_B: begin
        w_bready = 1'b1;
        if (m_axi.m_axi_bvalid) w_next = DONE;
      end
      RD_A: begin
        w_arvalid = 1'b1;
        if (m_axi.m_axi_arready) w_next = RD_R;
      end
      RD_R: begin
        w_rready = 1'b1;
        if (m_axi.m_axi_rvalid) w_next = DONE;
      end
      DONE: begin
        w_done[r_id] = 1'b1;
        w_next       = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Command latch, write-channel valids, response capture and RR pointer.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_last    <= 1'b1;
      r_id      <= 1'b0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_resp    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_id      <= w_gid;
            r_addr    <= BASE_ADDR + {28'd0, w_sel_idx, 2'b00};
            r_wdata   <= w_sel_wdata;
            r_awvalid <= w_sel_write;
            r_wvalid  <= w_sel_write;
          end
        end
        WR: begin
          if (w_aw_hs) r_awvalid <= 1'b0;
          if (w_w_hs)  r_wvalid  <= 1'b0;
        end
        WR_B: begin
          if (m_axi.m_axi_bvalid) begin
            r_resp  <= m_axi.m_axi_bresp;
            r_rdata <= '0;
          end
        end
        RD_R: begin
          if (m_axi.m_axi_rvalid) begin
            r_rdata <= m_axi.m_axi_rdata;
            r_resp  <= m_axi.m_axi_rresp;
          end
        end
        DONE: r_last <= r_id;
        default: ;
      endcase
    end
  end

  assign req_ack = w_ack;
  assign done    = w_done;
  assign rdata   = r_rdata;
  assign resp    = r_resp;

  assign m_axi.m_axi_awaddr  = r_addr;
  assign m_axi.m_axi_awvalid = r_awvalid;
  assign m_axi.m_axi_wdata   = r_wdata;
  assign m_axi.m_axi_wstrb   = 4'hF;
  assign m_axi.m_axi_wvalid  = r_wvalid;
  assign m_axi.m_axi_bready  = w_bready;
  assign m_axi.m_axi_araddr  = r_addr;
  assign m_axi.m_axi_arvalid = w_arvalid;
  assign m_axi.m_axi_rready  = w_rready;

endmodule

// File: tb/tb_colordetect_cfg_arbiter.sv
// Directed bench for colordetect_cfg_arbiter with a small AXI4-Lite slave
// model (4-word memory, programmable awready delay, bresp and read stall).
module tb_colordetect_cfg_arbiter;
  localparam logic [31:0] BASE = 32'h4000_0010;

  logic        ACLK;
  logic        ARESET;
  logic [1:0]  req_valid;
  logic [1:0]  req_write;
  logic [3:0]  req_idx;
  logic [63:0] req_wdata;
  logic [1:0]  req_ack;
  logic [1:0]  done;
  logic [31:0] rdata;
  logic [1:0]  resp;

  colordetect_cfg_arbiter_if ifc ();

  colordetect_cfg_arbiter #(.BASE_ADDR(BASE)) dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_idx   (req_idx),
    .req_wdata (req_wdata),
    .req_ack   (req_ack),
    .done      (done),
    .rdata     (rdata),
    .resp      (resp),
    .m_axi     (ifc.master)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // ---------------- slave model ----------------
  int          aw_delay;
  logic [1:0]  s_bresp;
  logic        rstall;
  int          aw_cnt;
  logic        got_aw, got_w, s_bvalid, s_rvalid;
  logic [31:0] s_awaddr, s_wdata, s_rdata;
  logic [31:0] mem [4] = '{default: 32'h0};

  function automatic logic [1:0] slot(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return off[3:2];
  endfunction

  assign ifc.m_axi_awready = ifc.m_axi_awvalid && (aw_cnt >= aw_delay);
  assign ifc.m_axi_wready  = 1'b1;
  assign ifc.m_axi_bvalid  = s_bvalid;
  assign ifc.m_axi_bresp   = s_bresp;
  assign ifc.m_axi_arready = 1'b1;
  assign ifc.m_axi_rvalid  = s_rvalid;
  assign ifc.m_axi_rdata   = s_rdata;
  assign ifc.m_axi_rresp   = 2'b00;

  wire aw_hs = ifc.m_axi_awvalid & ifc.m_axi_awready;
  wire w_hs  = ifc.m_axi_wvalid  & ifc.m_axi_wready;
  wire ar_hs = ifc.m_axi_arvalid & ifc.m_axi_arready;

  always @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_cnt <= 0; got_aw <= 1'b0; got_w <= 1'b0;
      s_bvalid <= 1'b0; s_rvalid <= 1'b0;
      s_awaddr <= '0; s_wdata <= '0; s_rdata <= '0;
    end else begin
      if (ifc.m_axi_awvalid && !ifc.m_axi_awready) aw_cnt <= aw_cnt + 1;
      else aw_cnt <= 0;
      if (aw_hs) begin got_aw <= 1'b1; s_awaddr <= ifc.m_axi_awaddr; end
      if (w_hs)  begin got_w  <= 1'b1; s_wdata  <= ifc.m_axi_wdata;  end
      if (s_bvalid && ifc.m_axi_bready) begin
        s_bvalid <= 1'b0; got_aw <= 1'b0; got_w <= 1'b0;
      end else if (!s_bvalid && (got_aw || aw_hs) && (got_w || w_hs)) begin
        s_bvalid <= 1'b1;
      end
      if (s_rvalid && ifc.m_axi_rready) s_rvalid <= 1'b0;
      else if (ar_hs && !rstall) begin
        s_rvalid <= 1'b1;
        s_rdata  <= mem[slot(ifc.m_axi_araddr)];
      end
    end
  end

  always @(posedge ACLK) begin
    if (s_bvalid && ifc.m_axi_bready) mem[slot(s_awaddr)] <= s_wdata;
  end

  // ---------------- monitors ----------------
  int          n_done0, n_done1, n_aw_hi, n_w_hi, n_aw_unstable;
  logic        prev_awvalid;
  logic [31:0] prev_awaddr;
  initial begin
    n_done0 = 0; n_done1 = 0; n_aw_hi = 0; n_w_hi = 0; n_aw_unstable = 0;
    prev_awvalid = 1'b0; prev_awaddr = '0;
  end
  always @(posedge ACLK) begin
    if (done[0]) n_done0++;
    if (done[1]) n_done1++;
    if (ifc.m_axi_awvalid) n_aw_hi++;
    if (ifc.m_axi_wvalid)  n_w_hi++;
    if (ifc.m_axi_awvalid && prev_awvalid && ifc.m_axi_awaddr != prev_awaddr)
      n_aw_unstable++;
    prev_awvalid = ifc.m_axi_awvalid;
    prev_awaddr  = ifc.m_axi_awaddr;
  end

  // ---------------- checking helpers ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Steps cycle by cycle until done pulses; n = steps taken, -1 on timeout.
  task automatic wait_done(output int n);
    n = 0;
    while (done == 2'b00 && n < 20) begin
      @(negedge ACLK); #1; n++;
    end
    if (done == 2'b00) n = -1;
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    while (req_ack == 2'b00 && n < 20) begin
      @(negedge ACLK); #1; n++;
    end
    if (req_ack == 2'b00) n = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n, d0, d1, a0, w0, u0;
    ARESET = 1'b1; req_valid = '0; req_write = '0; req_idx = '0; req_wdata = '0;
    aw_delay = 0; s_bresp = 2'b00; rstall = 1'b0;
    repeat (2) @(negedge ACLK);

    // Reset state, including a valid request that must not be acked.
    req_valid = 2'b01; #1;
    check("rst_ack",    32'(req_ack), 0);
    check("rst_done",   32'(done), 0);
    check("rst_rdata",  rdata, 0);
    check("rst_resp",   32'(resp), 0);
    check("rst_valids", 32'({ifc.m_axi_awvalid, ifc.m_axi_wvalid, ifc.m_axi_arvalid,
                             ifc.m_axi_bready, ifc.m_axi_rready}), 0);
    check("rst_awaddr", ifc.m_axi_awaddr, 0);
    check("rst_wdata",  ifc.m_axi_wdata, 0);
    req_valid = 2'b00;
    @(negedge ACLK); ARESET = 1'b0;
    @(negedge ACLK);

    // Requester 0 writes idx 1.
    req_valid = 2'b01; req_write = 2'b01; req_idx = 4'b0001;
    req_wdata = {32'h0, 32'hABCD_0001}; #1;
    check("t1_ack", 32'(req_ack), 1);
    @(negedge ACLK); req_valid = 2'b00; #1;
    check("t1_aw_w_valid", 32'({ifc.m_axi_awvalid, ifc.m_axi_wvalid}), 3);
    check("t1_awaddr", ifc.m_axi_awaddr, BASE + 32'd4);
    check("t1_wdata",  ifc.m_axi_wdata, 32'hABCD_0001);
    check("t1_wstrb",  32'(ifc.m_axi_wstrb), 32'hF);
    wait_done(n);
    check("t1_latency", n + 1, 3);
    check("t1_done", 32'(done), 1);
    check("t1_resp", 32'(resp), 0);
    @(negedge ACLK); #1;
    check("t1_done_pulse", 32'(done), 0);

    // Requester 1 reads idx 1 back.
    d1 = n_done1;
    req_valid = 2'b10; req_write = 2'b00; req_idx = 4'b0100; #1;
    check("t2_ack", 32'(req_ack), 2);
    @(negedge ACLK); req_valid = 2'b00; #1;
    check("t2_arvalid", 32'(ifc.m_axi_arvalid), 1);
    check("t2_araddr", ifc.m_axi_araddr, BASE + 32'd4);
    wait_done(n);
    check("t2_latency", n + 1, 3);
    check("t2_done", 32'(done), 2);
    check("t2_rdata", rdata, 32'hABCD_0001);
    @(negedge ACLK); #1;
    check("t2_done_once", n_done1 - d1, 1);

    // Both requesters continuously valid: grants alternate 0,1,0,1.
    d0 = n_done0; d1 = n_done1;
    req_valid = 2'b11; req_write = 2'b00; req_idx = 4'b1000; #1;
    check("t3_grant0", 32'(req_ack), 1);
    for (int k = 1; k < 4; k++) begin
      @(negedge ACLK); #1;
      wait_ack(n);
      check("t3_gap", n + 1, 4);
      check("t3_grant", 32'(req_ack), (k % 2 == 1) ? 2 : 1);
    end
    @(negedge ACLK); req_valid = 2'b00; #1;
    check("t3_araddr", ifc.m_axi_araddr, BASE + 32'd8);
    wait_done(n);
    @(negedge ACLK); #1;
    check("t3_done0_count", n_done0 - d0, 2);
    check("t3_done1_count", n_done1 - d1, 2);

    // Late awready, immediate wready.
    aw_delay = 2;
    a0 = n_aw_hi; w0 = n_w_hi; u0 = n_aw_unstable; d0 = n_done0;
    req_valid = 2'b01; req_write = 2'b01; req_idx = 4'b0011;
    req_wdata = {32'h0, 32'h5A5A_1234}; #1;
    check("t4_ack", 32'(req_ack), 1);
    @(negedge ACLK); req_valid = 2'b00; #1;
    check("t4_awaddr", ifc.m_axi_awaddr, BASE + 32'd12);
    wait_done(n);
    check("t4_done", 32'(done), 1);
    @(negedge ACLK); #1;
    check("t4_awvalid_cycles", n_aw_hi - a0, 3);
    check("t4_wvalid_cycles",  n_w_hi - w0, 1);
    check("t4_awaddr_stable",  n_aw_unstable - u0, 0);
    check("t4_done_count",     n_done0 - d0, 1);
    aw_delay = 0;

    // SLVERR write response reported as-is, no retry.
    s_bresp = 2'b10; a0 = n_aw_hi;
    req_valid = 2'b01; req_write = 2'b01; req_idx = 4'b0000;
    req_wdata = {32'h0, 32'h0000_0011}; #1;
    check("t5_ack", 32'(req_ack), 1);
    @(negedge ACLK); req_valid = 2'b00; #1;
    wait_done(n);
    check("t5_done", 32'(done), 1);
    check("t5_resp", 32'(resp), 2);
    check("t5_rdata", rdata, 0);
    repeat (2) @(negedge ACLK); #1;
    check("t5_no_retry_aw", 32'(ifc.m_axi_awvalid), 0);
    check("t5_aw_attempts", n_aw_hi - a0, 1);
    s_bresp = 2'b00;

    // Reset while a read waits in RD_R.
    rstall = 1'b1; d0 = n_done0; d1 = n_done1;
    req_valid = 2'b10; req_write = 2'b00; req_idx = 4'b0100; #1;
    check("t6_ack", 32'(req_ack), 2);
    @(negedge ACLK); req_valid = 2'b00; #1;
    @(negedge ACLK); #1;
    check("t6_rready_before", 32'(ifc.m_axi_rready), 1);
    ARESET = 1'b1; #1;
    check("t6_ar_r_after_rst", 32'({ifc.m_axi_arvalid, ifc.m_axi_rready}), 0);
    check("t6_resp_cleared", 32'(resp), 0);
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0; rstall = 1'b0; #1;
    check("t6_no_done", (n_done0 - d0) + (n_done1 - d1), 0);

    // Fresh arbitration after reset: requester 0 wins the tie.
    req_valid = 2'b11; req_write = 2'b00; req_idx = 4'b0001; #1;
    check("t7_rearb", 32'(req_ack), 1);
    @(negedge ACLK); req_valid = 2'b00; #1;
    wait_done(n);
    check("t7_done", 32'(done), 1);
    check("t7_rdata", rdata, 32'hABCD_0001);

    @(negedge ACLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
